// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Brief    : Shared constants, types and helpers for the FP register file.
//  Revision : 1.0  initial release
// ============================================================================
package fpu_pkg;

    localparam int FLEN       = 32;
    localparam int FREG_N     = 32;
    localparam int FREG_AW    = 5;
    // Upper bound on write ports handled by the forwarding helper.
    localparam int FPR_MAX_WR = 8;

    typedef logic [FREG_AW-1:0] freg_idx_t;

    // Returns the highest-index set bit of a write-port hit vector, which
    // mirrors the array write priority (higher port index wins).
    function automatic int fpr_bypass_sel(input logic [FPR_MAX_WR-1:0] hits);
        int sel;
        sel = 0;
        for (int j = 0; j < FPR_MAX_WR; j++) begin
            if (hits[j]) begin
                sel = j;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpr_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fpr_scoreboard
//  Brief    : Per-register busy scoreboard for multi-cycle FPU ops. Issue
//             sets a bit, qualified writeback clears it; set wins over a
//             same-cycle clear. Lookups use registered state only.
//  Revision : 1.0  initial release
// ============================================================================
module fpr_scoreboard
    import fpu_pkg::*;
#(
    parameter int NREG = FREG_N,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 3,
    parameter int NWR  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR-1:0]    wclr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic            w_fire;

    assign iss_ready = ~r_busy[iss_rd];
    assign w_fire    = iss_valid & iss_ready;
    assign busy_vec  = r_busy;

    // Decode clear and set masks from writeback ports and the issue port.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wclr[j]) begin
                w_clr[waddr[j*AW +: AW]] = 1'b1;
            end
        end
        if (w_fire) begin
            w_set[iss_rd] = 1'b1;
        end
    end

    // Busy lookup for each read port from the registered state.
    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rbusy
            assign rbusy[i] = r_busy[raddr[i*AW +: AW]];
        end
    endgenerate

    // Busy state update: clear first, then set so that a new issue wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpr_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : fpr_file_sb
//  Brief    : FP register file, NRD synchronous read ports, NWR write ports
//             (higher index = higher priority), with busy scoreboard.
//             Optional macro FPR_BYPASS_EN enables same-cycle write-to-read
//             forwarding; without it reads return the pre-write value.
//  Revision : 1.0  initial release
// ============================================================================
module fpr_file_sb
    import fpu_pkg::*;
#(
    parameter int XLEN = FLEN,
    parameter int NREG = FREG_N,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 3,
    parameter int NWR  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NWR-1:0]      wclr,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    output logic [NREG-1:0]     busy_vec
);

    // Storage is deliberately not reset; contents are undefined until written.
    logic [XLEN-1:0]     r_mem [NREG];
    logic [NRD*XLEN-1:0] r_rdata;
    logic [NRD*XLEN-1:0] w_rd_next;
`ifdef FPR_BYPASS_EN
    logic [FPR_MAX_WR-1:0] w_hit;
`endif

    assign rdata = r_rdata;

    // Array write; later (higher-index) ports overwrite earlier ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j]) begin
                    r_mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Next read data per port: array value, optionally forwarded from writes.
    always_comb begin
        w_rd_next = '0;
`ifdef FPR_BYPASS_EN
        w_hit = '0;
`endif
        for (int i = 0; i < NRD; i++) begin
            w_rd_next[i*XLEN +: XLEN] = r_mem[raddr[i*AW +: AW]];
`ifdef FPR_BYPASS_EN
            w_hit = '0;
            for (int j = 0; j < NWR; j++) begin
                w_hit[j] = we[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW]);
            end
            if (|w_hit) begin
                w_rd_next[i*XLEN +: XLEN] = wdata[fpr_bypass_sel(w_hit)*XLEN +: XLEN];
            end
`endif
        end
    end

    // Registered read ports; held at zero while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_next;
        end
    end

    fpr_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD),
        .NWR  (NWR)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rbusy     (rbusy),
        .we        (we),
        .waddr     (waddr),
        .wclr      (wclr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy_vec  (busy_vec)
    );

endmodule
`default_nettype wire

// File: tb/tb_fpr_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpr_file_sb
//  Brief    : Self-checking bench for fpr_file_sb (table vectors plus a
//             hand-written issue/hold/clear sequence). Expected read data
//             follows FPR_BYPASS_EN when that macro is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpr_file_sb;

`ifdef FPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] raddr;
    logic [95:0] rdata;
    logic [2:0]  rbusy;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  wclr;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpr_file_sb dut (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .wclr      (wclr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy_vec  (busy_vec)
    );

    // Field order: rst, we, wa0, wd0, wa1, wd1, wclr, ra0, ra1, ra2, iv, ird,
    // pre-edge rbusy[0], pre-edge iss_ready, read-check mask, post-edge
    // rdata0..2, post-edge busy_vec.
    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  wclr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        iv;
        logic [4:0]  ird;
        logic        erbusy0;
        logic        eready;
        logic [2:0]  chk;
        logic [31:0] er0;
        logic [31:0] er1;
        logic [31:0] er2;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        we        = v.we;
        waddr     = {v.wa1, v.wa0};
        wdata     = {v.wd1, v.wd0};
        wclr      = v.wclr;
        raddr     = {v.ra2, v.ra1, v.ra0};
        iss_valid = v.iv;
        iss_rd    = v.ird;
    endtask

    task automatic idle();
        rst = 1'b0; we = '0; waddr = '0; wdata = '0; wclr = '0;
        raddr = '0; iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        tbl[0]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd31,
                    1'b0, 1'b1, 3'b111, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 2'b01, 5'd5, 32'h3F800000, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd5, 5'd0, 5'd0, 1'b0, 5'd17,
                    1'b0, 1'b1, 3'b001, 32'h3F800000, 32'h0, 32'h0, 32'h0};
        tbl[3]  = '{1'b0, 2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 2'b00, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b001, 32'h3F800000, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b001, 32'h22222222, 32'h0, 32'h0, 32'h0};
        tbl[5]  = '{1'b0, 2'b01, 5'd3, 32'h0BADF00D, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[6]  = '{1'b0, 2'b11, 5'd12, 32'hC0000000, 5'd3, 32'h40000000, 2'b00, 5'd5, 5'd3, 5'd3, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b111, 32'h3F800000,
                    BYP ? 32'h40000000 : 32'h0BADF00D, BYP ? 32'h40000000 : 32'h0BADF00D, 32'h0};
        tbl[7]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd12, 5'd3, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b011, 32'hC0000000, 32'h40000000, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, 2'b11, 5'd20, 32'hAAAA0000, 5'd20, 32'hBBBB0000, 2'b00, 5'd0, 5'd0, 5'd20, 1'b0, 5'd0,
                    1'b0, 1'b1, BYP ? 3'b100 : 3'b000, 32'h0, 32'h0, 32'hBBBB0000, 32'h0};
        tbl[9]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 5'd20, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'hBBBB0000, 32'h0};
        tbl[10] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd9, 5'd0, 5'd0, 1'b1, 5'd9,
                    1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h00000200};
        tbl[11] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd9, 5'd0, 5'd0, 1'b1, 5'd9,
                    1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h00000200};
        tbl[12] = '{1'b0, 2'b01, 5'd9, 32'h40400000, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 5'd0, 1'b0, 5'd9,
                    1'b1, 1'b0, BYP ? 3'b001 : 3'b000, 32'h40400000, 32'h0, 32'h0, 32'h0};
        tbl[13] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd9, 5'd0, 5'd0, 1'b0, 5'd9,
                    1'b0, 1'b1, 3'b001, 32'h40400000, 32'h0, 32'h0, 32'h0};
        tbl[14] = '{1'b0, 2'b10, 5'd0, 32'h0, 5'd4, 32'h40800000, 2'b10, 5'd4, 5'd0, 5'd0, 1'b1, 5'd4,
                    1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h00000010};
        tbl[15] = '{1'b0, 2'b00, 5'd4, 32'h0, 5'd4, 32'h0, 2'b11, 5'd4, 5'd0, 5'd0, 1'b0, 5'd4,
                    1'b1, 1'b0, 3'b001, 32'h40800000, 32'h0, 32'h0, 32'h00000010};
        tbl[16] = '{1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00, 5'd4, 5'd0, 5'd0, 1'b1, 5'd6,
                    1'b1, 1'b1, 3'b111, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[17] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd5, 5'd4, 5'd0, 1'b0, 5'd4,
                    1'b0, 1'b1, 3'b011, 32'h3F800000, 32'h40800000, 32'h0, 32'h0};
        tbl[18] = '{1'b0, 2'b01, 5'd4, 32'h41000000, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[19] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 3'b001, 32'h41000000, 32'h0, 32'h0, 32'h0};
        tbl[20] = '{1'b0, 2'b10, 5'd0, 32'h0, 5'd0, 32'h00000000, 2'b10, 5'd0, 5'd0, 5'd0, 1'b1, 5'd31,
                    1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h80000000};
        tbl[21] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd31, 5'd0, 5'd0, 1'b0, 5'd31,
                    1'b1, 1'b0, 3'b010, 32'h0, 32'h00000000, 32'h0, 32'h80000000};

        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            drive(tbl[k]);
            #1;
            check($sformatf("v%0d rbusy0", k), {31'b0, rbusy[0]}, {31'b0, tbl[k].erbusy0});
            check($sformatf("v%0d iss_ready", k), {31'b0, iss_ready}, {31'b0, tbl[k].eready});
            @(posedge clk);
            #1;
            check($sformatf("v%0d busy_vec", k), busy_vec, tbl[k].ebusy);
            if (tbl[k].chk[0]) check($sformatf("v%0d rdata0", k), rdata[31:0],  tbl[k].er0);
            if (tbl[k].chk[1]) check($sformatf("v%0d rdata1", k), rdata[63:32], tbl[k].er1);
            if (tbl[k].chk[2]) check($sformatf("v%0d rdata2", k), rdata[95:64], tbl[k].er2);
        end

        // Held issue to busy f31 while its writeback clears it: no set that
        // cycle, the clear lands, then the held issue fires on the next cycle.
        @(negedge clk);
        idle();
        iss_valid = 1'b1; iss_rd = 5'd31;
        we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd31}; wdata = {32'h0, 32'h3F000000};
        #1;
        check("seq hold iss_ready", {31'b0, iss_ready}, 32'h0);
        @(posedge clk); #1;
        check("seq clear busy_vec", busy_vec, 32'h0);
        @(negedge clk);
        we = 2'b00; wclr = 2'b00;
        #1;
        check("seq refire iss_ready", {31'b0, iss_ready}, 32'h1);
        @(posedge clk); #1;
        check("seq refire busy_vec", busy_vec, 32'h80000000);
        @(negedge clk);
        idle();
        raddr = {5'd0, 5'd0, 5'd31};
        @(posedge clk); #1;
        check("seq read f31", rdata[31:0], 32'h3F000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
